// File: rtl/inside_pkg.sv
// Shared types and default parameter values for the inside_scan_matcher slice.
package inside_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_INIT_BASE = 100;
  localparam int DEF_INIT_STEP = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inside_table.sv
// Value/valid register array with reset preload, one write port and one
// combinational indexed read port (reads see pre-edge contents).
module inside_table
  import inside_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int INIT_BASE = DEF_INIT_BASE,
  parameter int INIT_STEP = DEF_INIT_STEP,
  parameter int IDX_W     = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_vld,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_vld
);

  localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_val [DEPTH];
  logic              r_vld [DEPTH];
  logic              w_wr_ok;

  // Indices past the last entry are dropped rather than aliased.
  assign w_wr_ok = i_wr_en && ({1'b0, i_wr_idx} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_val[k] <= DATA_W'(INIT_BASE + k * INIT_STEP);
        r_vld[k] <= 1'b1;
      end
    end else if (w_wr_ok) begin
      r_val[i_wr_idx] <= i_wr_data;
      r_vld[i_wr_idx] <= i_wr_vld;
    end
  end

  assign o_rd_data = r_val[i_rd_idx];
  assign o_rd_vld  = r_vld[i_rd_idx];

endmodule

// File: rtl/inside_scan_matcher.sv
// Sequential membership test: scans the table one entry per cycle and
// reports the lowest enabled entry equal to the captured query.
module inside_scan_matcher
  import inside_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int INIT_BASE = DEF_INIT_BASE,
  parameter int INIT_STEP = DEF_INIT_STEP,
  localparam int IDX_W    = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_vld,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [IDX_W-1:0]  rsp_idx
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_query;
  logic [IDX_W-1:0]  r_idx;
  logic              r_rsp_hit;
  logic [IDX_W-1:0]  r_rsp_idx;

  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_vld;
  logic              w_accept;
  logic              w_hit;
  logic              w_last;
  logic              w_rsp_done;

  inside_table #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_BASE (INIT_BASE),
    .INIT_STEP (INIT_STEP),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wr_en),
    .i_wr_idx  (wr_idx),
    .i_wr_data (wr_data),
    .i_wr_vld  (wr_vld),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rd_data),
    .o_rd_vld  (w_rd_vld)
  );

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_hit      = (r_state == ST_SCAN) && w_rd_vld && (w_rd_data == r_query);
  assign w_last     = (r_idx == IDX_W'(DEPTH - 1));
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_hit || w_last) w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_query   <= '0;
      r_idx     <= '0;
      r_rsp_hit <= 1'b0;
      r_rsp_idx <= '0;
    end else begin
      if (w_accept) begin
        r_query <= req_data;
        r_idx   <= '0;
      end
      // First match wins: remaining entries are never examined after a hit.
      if (r_state == ST_SCAN) begin
        if (w_hit) begin
          r_rsp_hit <= 1'b1;
          r_rsp_idx <= r_idx;
        end else if (w_last) begin
          r_rsp_hit <= 1'b0;
          r_rsp_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_rsp_done) begin
        r_rsp_hit <= 1'b0;
        r_rsp_idx <= '0;
        r_idx     <= '0;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_hit   = r_rsp_hit;
  assign rsp_idx   = r_rsp_idx;

endmodule

// File: tb/tb_inside_scan_matcher.sv
// Bench for inside_scan_matcher: directed scenarios plus randomized traffic
// against an array-based lookup model (DEPTH=4) and a DEPTH=5 instance.
module tb_inside_scan_matcher;

  localparam int D4 = 4;
  localparam int D5 = 5;

  logic       clk = 1'b0;
  logic       rst;

  logic       wr_en, wr_vld, req_valid, rsp_ready;
  logic [1:0] wr_idx;
  logic [7:0] wr_data, req_data;
  logic       req_ready, rsp_valid, rsp_hit;
  logic [1:0] rsp_idx;

  logic       b_wr_en, b_wr_vld, b_req_valid, b_rsp_ready;
  logic [2:0] b_wr_idx;
  logic [7:0] b_wr_data, b_req_data;
  logic       b_req_ready, b_rsp_valid, b_rsp_hit;
  logic [2:0] b_rsp_idx;

  int n_tests = 0;
  int n_fail  = 0;

  int m_val [D4];
  bit m_vld [D4];

  always #5 clk = ~clk;

  inside_scan_matcher dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_vld(wr_vld),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
  );

  inside_scan_matcher #(.DEPTH(D5)) dut5 (
    .clk(clk), .rst(rst),
    .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_data(b_wr_data), .wr_vld(b_wr_vld),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_hit(b_rsp_hit), .rsp_idx(b_rsp_idx)
  );

  // Reference: linear search for the lowest enabled equal entry.
  task automatic model_reset();
    for (int k = 0; k < D4; k++) begin
      m_val[k] = (100 + 10 * k) % 256;
      m_vld[k] = 1'b1;
    end
  endtask

  function automatic void model_lookup(input int q, output bit hit, output int idx, output int lat);
    hit = 1'b0;
    idx = 0;
    lat = D4;
    for (int k = 0; k < D4; k++) begin
      if (!hit && m_vld[k] && m_val[k] == q) begin
        hit = 1'b1;
        idx = k;
        lat = k + 1;
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_write(input int idx, input int data, input bit vld);
    wr_en = 1'b1; wr_idx = idx[1:0]; wr_data = data[7:0]; wr_vld = vld;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_val[idx] = data % 256;
    m_vld[idx] = vld;
  endtask

  task automatic run_query(input int q, output int lat, output bit hit, output int idx, output bit ok);
    req_valid = 1'b1; req_data = q[7:0];
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 20);
    ok  = rsp_valid;
    hit = rsp_hit;
    idx = int'(rsp_idx);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic b_run_query(input int q, input int wr_at, output int lat, output bit hit, output int idx, output bit ok);
    b_req_valid = 1'b1; b_req_data = q[7:0];
    @(posedge clk); #1;
    b_req_valid = 1'b0; b_req_data = 8'($urandom);
    lat = 0;
    do begin
      b_wr_en = (lat == wr_at);
      @(posedge clk); #1;
      lat++;
    end while (!b_rsp_valid && lat < 20);
    b_wr_en = 1'b0;
    ok  = b_rsp_valid;
    hit = b_rsp_hit;
    idx = int'(b_rsp_idx);
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b hit=%b idx=%0d, want 1 0 0 0",
               req_ready, rsp_valid, rsp_hit, rsp_idx);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_hit_latency();
    int lat, idx, elat, eidx; bit hit, ok, ehit;
    model_lookup(120, ehit, eidx, elat);
    run_query(120, lat, hit, idx, ok);
    n_tests++;
    if (!ok || lat !== 3 || hit !== 1'b1 || idx !== 2 || elat !== 3) begin
      n_fail++;
      $display("FAIL hit_120: got ok=%b lat=%0d hit=%b idx=%0d, want lat=3 hit=1 idx=2 (model lat=%0d)",
               ok, lat, hit, idx, elat);
    end
  endtask

  task automatic test_miss_then_write();
    int lat, idx, elat, eidx; bit hit, ok, ehit;
    model_lookup(105, ehit, eidx, elat);
    run_query(105, lat, hit, idx, ok);
    n_tests++;
    if (!ok || lat !== elat || hit !== ehit || idx !== eidx) begin
      n_fail++;
      $display("FAIL miss_105: got ok=%b lat=%0d hit=%b idx=%0d, want lat=%0d hit=%b idx=%0d",
               ok, lat, hit, idx, elat, ehit, eidx);
    end
    do_write(1, 105, 1'b1);
    model_lookup(105, ehit, eidx, elat);
    run_query(105, lat, hit, idx, ok);
    n_tests++;
    if (!ok || lat !== elat || hit !== ehit || idx !== eidx) begin
      n_fail++;
      $display("FAIL hit_105_after_write: got ok=%b lat=%0d hit=%b idx=%0d, want lat=%0d hit=%b idx=%0d",
               ok, lat, hit, idx, elat, ehit, eidx);
    end
  endtask

  task automatic test_lowest_index();
    int lat, idx, elat, eidx; bit hit, ok, ehit;
    do_write(0, 130, 1'b1);
    model_lookup(130, ehit, eidx, elat);
    run_query(130, lat, hit, idx, ok);
    n_tests++;
    if (!ok || lat !== elat || hit !== ehit || idx !== eidx) begin
      n_fail++;
      $display("FAIL lowest_wins: got ok=%b lat=%0d hit=%b idx=%0d, want lat=%0d hit=%b idx=%0d",
               ok, lat, hit, idx, elat, ehit, eidx);
    end
    do_write(0, 130, 1'b0);
    model_lookup(130, ehit, eidx, elat);
    run_query(130, lat, hit, idx, ok);
    n_tests++;
    if (!ok || lat !== elat || hit !== ehit || idx !== eidx) begin
      n_fail++;
      $display("FAIL disabled_entry: got ok=%b lat=%0d hit=%b idx=%0d, want lat=%0d hit=%b idx=%0d",
               ok, lat, hit, idx, elat, ehit, eidx);
    end
  endtask

  task automatic test_hold();
    int lat, elat, eidx; bit ehit; bit stable;
    model_lookup(120, ehit, eidx, elat);
    req_valid = 1'b1; req_data = 8'd120;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 20);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 2); req_data = 8'd100;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_hit !== ehit || int'(rsp_idx) !== eidx)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_tests++;
    if (!stable || lat !== elat) begin
      n_fail++;
      $display("FAIL hold_stable: got stable=%b lat=%0d vld=%b hit=%b idx=%0d, want stable=1 lat=%0d hit=%b idx=%0d",
               stable, lat, rsp_valid, rsp_hit, rsp_idx, elat, ehit, eidx);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got vld=%b rdy=%b, want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_pulse_ignored: got rdy=%b, want 1", req_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, idx, elat, eidx; bit hit, ok, ehit, seen;
    req_valid = 1'b1; req_data = 8'd130;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1; wr_en = 1'b1; wr_idx = 2'd3; wr_data = 8'd7; wr_vld = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    model_reset();
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: got rdy=%b vld=%b, want 1 0", req_ready, rsp_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_rsp: got rsp_valid seen=1, want 0");
    end
    for (int k = 0; k < D4; k++) begin
      model_lookup(100 + 10 * k, ehit, eidx, elat);
      run_query(100 + 10 * k, lat, hit, idx, ok);
      n_tests++;
      if (!ok || lat !== elat || hit !== ehit || idx !== eidx || idx !== k) begin
        n_fail++;
        $display("FAIL table_init[%0d]: got ok=%b lat=%0d hit=%b idx=%0d, want lat=%0d hit=1 idx=%0d",
                 k, ok, lat, hit, idx, elat, k);
      end
    end
  endtask

  task automatic test_random();
    int lat, idx, elat, eidx, q, errs; bit hit, ok, ehit;
    errs = 0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1, 0) == 1)
        do_write($urandom_range(3, 0), 90 + 10 * $urandom_range(5, 0), $urandom_range(3, 0) != 0);
      q = ($urandom_range(4, 0) == 0) ? $urandom_range(255, 0) : 90 + 10 * $urandom_range(5, 0);
      model_lookup(q, ehit, eidx, elat);
      run_query(q, lat, hit, idx, ok);
      n_tests++;
      if (!ok || lat !== elat || hit !== ehit || idx !== eidx) begin
        n_fail++;
        errs++;
        if (errs < 5)
          $display("FAIL random[%0d] q=%0d: got ok=%b lat=%0d hit=%b idx=%0d, want lat=%0d hit=%b idx=%0d",
                   it, q, ok, lat, hit, idx, elat, ehit, eidx);
      end
    end
  endtask

  task automatic test_depth5();
    int lat, idx; bit hit, ok;
    b_wr_en = 1'b1; b_wr_idx = 3'd6; b_wr_data = 8'd77; b_wr_vld = 1'b1;
    @(posedge clk); #1;
    b_wr_en = 1'b0;
    // Write of entry 2 lands on the edge that ends its compare cycle.
    b_wr_idx = 3'd2; b_wr_data = 8'd77; b_wr_vld = 1'b1;
    b_run_query(77, 2, lat, hit, idx, ok);
    n_tests++;
    if (!ok || lat !== 5 || hit !== 1'b0 || idx !== 0) begin
      n_fail++;
      $display("FAIL d5_same_edge_write: got ok=%b lat=%0d hit=%b idx=%0d, want lat=5 hit=0 idx=0",
               ok, lat, hit, idx);
    end
    b_run_query(77, -1, lat, hit, idx, ok);
    n_tests++;
    if (!ok || lat !== 3 || hit !== 1'b1 || idx !== 2) begin
      n_fail++;
      $display("FAIL d5_after_write: got ok=%b lat=%0d hit=%b idx=%0d, want lat=3 hit=1 idx=2",
               ok, lat, hit, idx);
    end
    b_run_query(140, -1, lat, hit, idx, ok);
    n_tests++;
    if (!ok || lat !== 5 || hit !== 1'b1 || idx !== 4) begin
      n_fail++;
      $display("FAIL d5_last_entry: got ok=%b lat=%0d hit=%b idx=%0d, want lat=5 hit=1 idx=4",
               ok, lat, hit, idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_vld = 1'b0;
    req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
    b_wr_en = 1'b0; b_wr_idx = '0; b_wr_data = '0; b_wr_vld = 1'b0;
    b_req_valid = 1'b0; b_req_data = '0; b_rsp_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_hit_latency();
    test_miss_then_write();
    test_lowest_index();
    test_hold();
    test_reset_mid_scan();
    test_random();
    do_reset();
    test_depth5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
